// File: rtl/multi_phase_traffic_controller.sv
// multi_phase_traffic_controller: round-robin GREEN -> AMBER -> ALL_RED sequencer
// for NUM_PHASES mutually exclusive phases, with latched pedestrian requests
// serviced as WALK then flashing DONT_WALK at the start of the phase's green.
// All lamp outputs are registered from next-state values, so a lamp change
// becomes visible on the cycle after the tick that causes it.
module multi_phase_traffic_controller #(
  parameter int NUM_PHASES  = 4,
  parameter int CLK_PER_SEC = 27000000,
  parameter int DEBUG_DIV   = 10,
  parameter int GREEN_SEC   = 10,
  parameter int AMBER_SEC   = 3,
  parameter int ALL_RED_SEC = 2,
  parameter int WALK_SEC    = 4,
  parameter int FLASH_SEC   = 4,
  localparam int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  debug,
  input  logic [NUM_PHASES-1:0] walk_request,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] amber,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] walk,
  output logic [NUM_PHASES-1:0] dont_walk,
  output logic                  walk_request_waiting,
  output logic [PHASE_W-1:0]    active_phase
);

  localparam int DBG_RAW = CLK_PER_SEC / DEBUG_DIV;
  localparam int DBG_T   = (DBG_RAW < 1) ? 1 : DBG_RAW;
  localparam int PRE_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int MAX_GA  = (GREEN_SEC > AMBER_SEC) ? GREEN_SEC : AMBER_SEC;
  localparam int MAX_SEC = (MAX_GA > ALL_RED_SEC) ? MAX_GA : ALL_RED_SEC;
  localparam int SEC_W   = $clog2(MAX_SEC + 1);

  localparam logic [PRE_W-1:0] NORM_LAST    = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [PRE_W-1:0] DBG_LAST     = PRE_W'(DBG_T - 1);
  localparam logic [SEC_W-1:0] GREEN_LAST   = SEC_W'(GREEN_SEC - 1);
  localparam logic [SEC_W-1:0] AMBER_LAST   = SEC_W'(AMBER_SEC - 1);
  localparam logic [SEC_W-1:0] ALL_RED_LAST = SEC_W'(ALL_RED_SEC - 1);
  localparam logic [SEC_W-1:0] WALK_END     = SEC_W'(WALK_SEC);
  localparam logic [SEC_W-1:0] FLASH_END    = SEC_W'(WALK_SEC + FLASH_SEC);
  // Parity of (sec - WALK_SEC) equals parity of sec xor parity of WALK_SEC.
  localparam logic             WALK_ODD     = (WALK_SEC % 2) != 0;

  typedef enum logic [1:0] {ST_STARTUP, ST_GREEN, ST_AMBER, ST_ALL_RED} state_e;

  state_e                  state_q, state_d;
  logic [PRE_W-1:0]        presc_q, presc_d, presc_last;
  logic [SEC_W-1:0]        sec_q, sec_d, sec_last;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [NUM_PHASES-1:0]   latch_q, latch_d;
  logic                    armed_q, armed_d;
  logic                    tick, expire;
  logic [NUM_PHASES-1:0]   green_d, amber_d, red_d, walk_d, dont_walk_d;

  // One-second prescaler; ">=" lets a shortened period (debug raised) wrap at once.
  always_comb begin
    presc_last = debug ? DBG_LAST : NORM_LAST;
    tick       = (presc_q >= presc_last);
    presc_d    = tick ? '0 : presc_q + PRE_W'(1);
  end

  // Next-state logic: phase sequencing, second counter, request latches.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    latch_d = latch_q | walk_request;
    armed_d = armed_q;
    unique case (state_q)
      ST_GREEN: sec_last = GREEN_LAST;
      ST_AMBER: sec_last = AMBER_LAST;
      default:  sec_last = ALL_RED_LAST;
    endcase
    expire = tick && (sec_q == sec_last);
    unique case (state_q)
      ST_STARTUP: if (expire) begin
        state_d = ST_GREEN;
        phase_d = '0;
      end
      ST_GREEN:   if (expire) state_d = ST_AMBER;
      ST_AMBER:   if (expire) state_d = ST_ALL_RED;
      ST_ALL_RED: if (expire) begin
        state_d = ST_GREEN;
        phase_d = (phase_q == PHASE_W'(NUM_PHASES - 1)) ? '0 : phase_q + PHASE_W'(1);
      end
      default:    state_d = ST_STARTUP;
    endcase
    sec_d = (state_d != state_q) ? '0 : (tick ? sec_q + SEC_W'(1) : sec_q);
    // The entry cycle is the one whose edge loads GREEN; a request seen on
    // that same cycle is folded into latch_d and therefore serviced now.
    if (state_d != ST_GREEN) begin
      armed_d = 1'b0;
    end else if (state_q != ST_GREEN) begin
      armed_d = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (phase_d == PHASE_W'(i)) begin
          armed_d    = latch_d[i];
          latch_d[i] = 1'b0;
        end
      end
    end
  end

  // Output decode from next-state values, registered below.
  always_comb begin
    green_d     = '0;
    amber_d     = '0;
    red_d       = '1;
    walk_d      = '0;
    dont_walk_d = '1;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase_d == PHASE_W'(i)) begin
        unique case (state_d)
          ST_GREEN: begin
            green_d[i] = 1'b1;
            red_d[i]   = 1'b0;
            if (armed_d) begin
              if (sec_d < WALK_END) begin
                walk_d[i]      = 1'b1;
                dont_walk_d[i] = 1'b0;
              end else if (sec_d < FLASH_END) begin
                dont_walk_d[i] = sec_d[0] ^ WALK_ODD;
              end
            end
          end
          ST_AMBER: begin
            amber_d[i] = 1'b1;
            red_d[i]   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // State register: FSM, timers, latches and phase index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      presc_q <= '0;
      sec_q   <= '0;
      phase_q <= '0;
      latch_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      phase_q <= phase_d;
      latch_q <= latch_d;
      armed_q <= armed_d;
    end
  end

  // Output register: lamps and pedestrian symbols.
  always_ff @(posedge clk) begin
    if (reset) begin
      green     <= '0;
      amber     <= '0;
      red       <= '1;
      walk      <= '0;
      dont_walk <= '1;
    end else begin
      green     <= green_d;
      amber     <= amber_d;
      red       <= red_d;
      walk      <= walk_d;
      dont_walk <= dont_walk_d;
    end
  end

  assign walk_request_waiting = |latch_q;
  assign active_phase         = phase_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed bench for multi_phase_traffic_controller: 2 phases, 10 clk/second,
// green 6 s, amber 2 s, all-red 1 s, walk 2 s, flash 2 s.
// Cycle 1 is the first cycle after reset release; lamps from a tick on
// cycle k show from cycle k+1.
module tb_multi_phase_traffic_controller;
  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          debug = 1'b0;
  logic [NP-1:0] walk_request = '0;
  logic [NP-1:0] green, amber, red, walk, dont_walk;
  logic          walk_request_waiting;
  logic          active_phase;
  logic [11:0]   obs;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  multi_phase_traffic_controller #(
    .NUM_PHASES(2), .CLK_PER_SEC(10), .DEBUG_DIV(10), .GREEN_SEC(6),
    .AMBER_SEC(2), .ALL_RED_SEC(1), .WALK_SEC(2), .FLASH_SEC(2)
  ) dut (
    .clk(clk), .reset(reset), .debug(debug), .walk_request(walk_request),
    .green(green), .amber(amber), .red(red), .walk(walk), .dont_walk(dont_walk),
    .walk_request_waiting(walk_request_waiting), .active_phase(active_phase)
  );

  // {green, amber, red, walk, dont_walk, waiting, active_phase}
  assign obs = {green, amber, red, walk, dont_walk, walk_request_waiting, active_phase};

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_after_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %b expected %b", obs, exp); end
    reset = 1'b0;
    cyc = 1;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL startup_c1: got %b expected %b", obs, exp); end
    goto(10);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL startup_c10: got %b expected %b", obs, exp); end
    goto(11);
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL first_green_c11: got %b expected %b", obs, exp); end
    $display("test_reset: startup checked through cycle %0d", cyc);
  endtask

  task automatic test_request_latch();
    logic [11:0] exp;
    goto(30);
    walk_request = 2'b10;
    goto(31);
    walk_request = 2'b00;
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL latch_c31: got %b expected %b", obs, exp); end
    goto(40);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL latch_hold_c40: got %b expected %b", obs, exp); end
    $display("test_request_latch: phase-1 request pulsed at cycle 30");
  endtask

  task automatic test_lamp_sequence();
    logic [11:0] exp;
    goto(70);
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL green_end_c70: got %b expected %b", obs, exp); end
    goto(71);
    exp = {2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL amber_c71: got %b expected %b", obs, exp); end
    goto(90);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL amber_end_c90: got %b expected %b", obs, exp); end
    goto(91);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL all_red_c91: got %b expected %b", obs, exp); end
    goto(100);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL all_red_c100: got %b expected %b", obs, exp); end
    goto(101);
    exp = {2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL green1_walk_c101: got %b expected %b", obs, exp); end
    $display("test_lamp_sequence: phase 0 -> phase 1 handover checked");
  endtask

  task automatic test_walk_service();
    logic [5:0] exp, got;
    for (int c = 102; c <= 170; c++) begin
      goto(c);
      exp[5:4] = (c <= 160) ? 2'b10 : 2'b00;
      exp[3:2] = (c <= 120) ? 2'b10 : 2'b00;
      exp[1:0] = (c <= 130) ? 2'b01 : 2'b11;
      got = {green, walk, dont_walk};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL walk_seq_c%0d: got %b expected %b", c, got, exp);
      end
    end
    $display("test_walk_service: phase-1 walk/flash checked cycles 102..170");
  endtask

  task automatic test_entry_request();
    logic [11:0] exp;
    logic [4:0]  e5, g5;
    goto(190);
    walk_request = 2'b01;
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL all_red_c190: got %b expected %b", obs, exp); end
    goto(191);
    walk_request = 2'b00;
    exp = {2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL entry_walk_c191: got %b expected %b", obs, exp); end
    for (int c = 192; c <= 219; c++) begin
      goto(c);
      e5 = {((c <= 210) ? 2'b01 : 2'b00), 2'b10, 1'b0};
      g5 = {walk, dont_walk, walk_request_waiting};
      n_checks++;
      if (g5 !== e5) begin n_fail++; $display("FAIL entry_seq_c%0d: got %b expected %b", c, g5, e5); end
    end
    $display("test_entry_request: request on entry cycle 190 serviced");
  endtask

  task automatic test_midgreen_request();
    logic [11:0] exp;
    goto(220);
    walk_request = 2'b01;
    goto(221);
    walk_request = 2'b00;
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL mid_latch_c221: got %b expected %b", obs, exp); end
    goto(240);
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL mid_no_walk_c240: got %b expected %b", obs, exp); end
    goto(370);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pending_c370: got %b expected %b", obs, exp); end
    goto(371);
    exp = {2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL next_green_walk_c371: got %b expected %b", obs, exp); end
    $display("test_midgreen_request: deferred to next phase-0 green");
  endtask

  task automatic test_debug();
    logic [11:0] exp;
    debug = 1'b1;
    release_after_reset(3);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_c1: got %b expected %b", obs, exp); end
    goto(2);
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_green0_c2: got %b expected %b", obs, exp); end
    goto(7);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_green0_c7: got %b expected %b", obs, exp); end
    goto(8);
    exp = {2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_amber0_c8: got %b expected %b", obs, exp); end
    goto(10);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_all_red_c10: got %b expected %b", obs, exp); end
    goto(11);
    exp = {2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_green1_c11: got %b expected %b", obs, exp); end
    goto(19);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_all_red_c19: got %b expected %b", obs, exp); end
    goto(20);
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL dbg_wrap_c20: got %b expected %b", obs, exp); end
    debug = 1'b0;
    $display("test_debug: 18-cycle accelerated round checked");
  endtask

  task automatic test_reset_midop();
    logic [11:0] exp;
    release_after_reset(3);
    goto(30);
    walk_request = 2'b10;
    goto(31);
    walk_request = 2'b00;
    goto(105);
    walk_request = 2'b01;
    goto(106);
    walk_request = 2'b00;
    exp = {2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pre_reset_walk_c106: got %b expected %b", obs, exp); end
    goto(110);
    reset = 1'b1;
    @(negedge clk);
    exp = {2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL midop_reset: got %b expected %b", obs, exp); end
    release_after_reset(2);
    goto(10);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_c10: got %b expected %b", obs, exp); end
    goto(11);
    exp = {2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_green_c11: got %b expected %b", obs, exp); end
    goto(71);
    exp = {2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart_amber_c71: got %b expected %b", obs, exp); end
    $display("test_reset_midop: reset during phase-1 walk checked");
  endtask

  initial begin
    test_reset();
    test_request_latch();
    test_lamp_sequence();
    test_walk_service();
    test_entry_request();
    test_midgreen_request();
    test_debug();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_phase_traffic_controller.md
Name: multi_phase_traffic_controller

Overview:
- Parametrised traffic-signal controller for NUM_PHASES mutually exclusive signal phases.
- Sequences each phase through GREEN, AMBER and ALL_RED in round-robin order.
- Services latched pedestrian walk requests with WALK, then flashing DONT_WALK, inside that phase's green.
- Sits behind the board test bench in place of the fixed four-approach controller; hex/LED decoding stays outside the block.

Parameters:
- NUM_PHASES, 4: number of signal phases; minimum 2.
- CLK_PER_SEC, 27000000: clk cycles per one-second tick.
- DEBUG_DIV, 10: divisor applied to CLK_PER_SEC while debug=1.
- GREEN_SEC, 10: green duration in seconds; must be >= WALK_SEC+FLASH_SEC.
- AMBER_SEC, 3: amber duration in seconds.
- ALL_RED_SEC, 2: all-red clearance duration in seconds, also used for the startup interval.
- WALK_SEC, 4: steady WALK duration in seconds.
- FLASH_SEC, 4: flashing DONT_WALK duration in seconds.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- debug  in  1  1 = accelerated timing (tick every CLK_PER_SEC/DEBUG_DIV cycles)
- walk_request  in  NUM_PHASES  active-high pedestrian request per phase; pulse or level
- green  out  NUM_PHASES  green lamp per phase
- amber  out  NUM_PHASES  amber lamp per phase
- red  out  NUM_PHASES  red lamp per phase
- walk  out  NUM_PHASES  WALK symbol per phase
- dont_walk  out  NUM_PHASES  DONT_WALK symbol per phase; flashes during FLASH
- walk_request_waiting  out  1  OR of all latched, unserviced requests
- active_phase  out  max(1,$clog2(NUM_PHASES))  index of the phase currently in GREEN, AMBER or ALL_RED

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).

Reset:
- Enter STARTUP; prescaler=0, second counter=0, active_phase=0, request latches=0.
- Outputs: red all 1; green, amber, walk all 0; dont_walk all 1; walk_request_waiting=0.

Tick generation:
- Prescaler counts 0..T-1, where T=CLK_PER_SEC, or CLK_PER_SEC/DEBUG_DIV when debug=1.
- tick=1 on the cycle the prescaler equals T-1; the prescaler wraps to 0 on that cycle.
- If debug changes and the prescaler is already >= the new T-1, it wraps on the next cycle.

State machine (second counter cleared on every state entry; a state with duration D exits on the tick that brings the counter to D):
- STARTUP: all red for ALL_RED_SEC, then GREEN with phase 0.
- GREEN: green[active_phase]=1, red[active_phase]=0. Lasts GREEN_SEC, then AMBER.
- AMBER: amber[active_phase]=1, others red. Lasts AMBER_SEC, then ALL_RED.
- ALL_RED: all red. Lasts ALL_RED_SEC, then GREEN with active_phase+1, wrapping NUM_PHASES-1 to 0.

Walk servicing:
- On GREEN entry, if latch[p] is set for the new phase p: latch[p] clears and the walk sub-sequence is armed.
- Sub-sequence: WALK_SEC seconds of walk[p]=1, dont_walk[p]=0.
- Then FLASH_SEC seconds of walk[p]=0, with dont_walk[p]=0 during even seconds of the flash (0,2,...) and 1 during odd seconds.
- Then dont_walk[p]=1 for the rest of GREEN.
- Unarmed phase: dont_walk stays 1 throughout.
- All non-active phases: walk=0, dont_walk=1 at all times.

Request latches:
- latch[i] sets on any cycle with walk_request[i]=1.
- A request arriving on the GREEN-entry cycle of its own phase is serviced immediately (clear wins).
- A request arriving after that entry stays latched for the phase's next green.

Invariants:
- Exactly one of green/amber/red per phase each cycle.
- At most one phase non-red at any time.
- walk=1 only for the active phase, and only in GREEN.

Reset mid-operation: returns to STARTUP on the next edge, regardless of state; pending requests are discarded.

Outputs are registered, so lamp changes appear on the cycle after the tick that causes them.

Test Plan:
- Bench parameters: NUM_PHASES=2, CLK_PER_SEC=10, GREEN=6, AMBER=2, ALL_RED=1, WALK=2, FLASH=2, debug=0.
- Reset for 3 cycles, release -> all red/dont_walk for 10 cycles; green[0]=1 from cycle 11; amber[0] at +60; all red at +80; green[1], active_phase=1 at +90.
- walk_request[1] pulsed 1 cycle during phase-0 green -> walk_request_waiting=1 until phase-1 green entry; walk[1]=1 for 20 cycles; dont_walk[1] pattern 0,1 per 10 cycles over 20 cycles; then 1.
- walk_request[0] asserted exactly on phase-0 GREEN-entry cycle -> serviced in that green; waiting=0 afterwards.
- walk_request[0] asserted mid phase-0 green -> no walk this green; walk[0] in the following phase-0 green (cycle +180 relative to first green).
- debug=1 with DEBUG_DIV=10 -> tick every cycle; full 2-phase cycle completes in 18 cycles.
- reset asserted during WALK of phase 1 -> next cycle all red, walk all 0, waiting=0, active_phase=0; restart timing matches the first scenario.
